// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_pkg
//  Description : Shared definitions for the 4-digit FND scan controller:
//                segment codes, converter state encoding, sizes and the
//                digit-to-segment decode helper.
//                Optional build macro used by the controller: FND_LZ_BLANK_EN
//  Revision    : 1.0  initial release
// ============================================================================
package fnd_pkg;

    // Display geometry and input width ({carry, sum[7:0]})
    localparam int DIGITS = 4;
    localparam int VAL_W  = 9;

    // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp always off
    localparam logic [7:0] c_SEG_0     = 8'hC0;
    localparam logic [7:0] c_SEG_1     = 8'hF9;
    localparam logic [7:0] c_SEG_2     = 8'hA4;
    localparam logic [7:0] c_SEG_3     = 8'hB0;
    localparam logic [7:0] c_SEG_4     = 8'h99;
    localparam logic [7:0] c_SEG_5     = 8'h92;
    localparam logic [7:0] c_SEG_6     = 8'h82;
    localparam logic [7:0] c_SEG_7     = 8'hF8;
    localparam logic [7:0] c_SEG_8     = 8'h80;
    localparam logic [7:0] c_SEG_9     = 8'h90;
    localparam logic [7:0] c_SEG_BLANK = 8'hFF;

    // Binary-to-BCD converter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } conv_state_t;

    // Map one BCD digit to its segment pattern; non-decimal values go dark
    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = c_SEG_0;
            4'd1:    seg = c_SEG_1;
            4'd2:    seg = c_SEG_2;
            4'd3:    seg = c_SEG_3;
            4'd4:    seg = c_SEG_4;
            4'd5:    seg = c_SEG_5;
            4'd6:    seg = c_SEG_6;
            4'd7:    seg = c_SEG_7;
            4'd8:    seg = c_SEG_8;
            4'd9:    seg = c_SEG_9;
            default: seg = c_SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. One shift per cycle,
//                VAL_W shifts per conversion, followed by a one-cycle LOAD
//                state during which the finished BCD word is presented with
//                done high.
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VAL_W-1:0]      bin,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int ITER_W = $clog2(VAL_W);
    localparam logic [ITER_W-1:0] c_LAST_ITER = ITER_W'(VAL_W - 1);

    conv_state_t         r_state;
    logic [BCD_W-1:0]    r_bcd;
    logic [VAL_W-1:0]    r_bin;
    logic [ITER_W-1:0]   r_iter;
    logic [BCD_W-1:0]    w_bcd_adj;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_bcd_adj[4*gi +: 4] = (r_bcd[4*gi +: 4] >= 4'd5)
                                    ? r_bcd[4*gi +: 4] + 4'd3
                                    : r_bcd[4*gi +: 4];
    end

    // Converter FSM: capture on start, shift VAL_W times, then present result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_bin   <= '0;
            r_iter  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin;
                        r_bcd   <= '0;
                        r_iter  <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // {bcd, bin} shifted left by one, corrected nibbles entering
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[VAL_W-1]};
                    r_bin <= {r_bin[VAL_W-2:0], 1'b0};
                    if (r_iter == c_LAST_ITER) begin
                        r_state <= LOAD;
                    end else begin
                        r_iter <= r_iter + 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bcd  = r_bcd;
    assign busy = (r_state != IDLE);
    assign done = (r_state == LOAD);

endmodule
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_ctrl
//  Description : 4-digit common-anode 7-segment scan controller. Converts the
//                9-bit adder result to BCD, latches it into a display
//                register and multiplexes the digits at SCAN_HZ.
//                Build macro FND_LZ_BLANK_EN: blank leading zeros (digit 0 is
//                never blanked). Undefined: all four digits always shown.
//  Revision    : 1.0  initial release
// ============================================================================
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
)(
    input  logic               clk,
    input  logic               reset,
    input  logic [VAL_W-1:0]   sum,
    output logic [7:0]         fnd_data,
    output logic [DIGITS-1:0]  fnd_com,
    output logic               busy
);

    // Cycles per digit; the configuration must keep this at 2 or more
    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int BCD_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  c_TICK_MAX = CNT_W'(DIV - 1);
    localparam logic [DIGITS-1:0] c_COM_LSB  = DIGITS'(1);
    localparam logic [DIGITS-1:0] c_COM_RST  = ~c_COM_LSB;

    logic [CNT_W-1:0]   r_tick_cnt;
    logic               w_tick;
    logic [IDX_W-1:0]   r_idx;
    logic [VAL_W-1:0]   r_last_val;
    logic [BCD_W-1:0]   r_disp;
    logic [7:0]         r_fnd_data;
    logic [DIGITS-1:0]  r_fnd_com;

    logic               w_start;
    logic               w_conv_busy;
    logic               w_conv_done;
    logic [BCD_W-1:0]   w_conv_bcd;
    logic [3:0]         w_digit;
    logic [DIGITS-1:0]  w_blank;
    logic [7:0]         w_seg;

    // A new conversion is only launched from idle; mid-conversion changes
    // are picked up by this same compare once the converter returns to idle.
    assign w_start = !w_conv_busy && (sum != r_last_val);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (sum),
        .start (w_start),
        .bcd   (w_conv_bcd),
        .busy  (w_conv_busy),
        .done  (w_conv_done)
    );

    // Scan-rate tick: one-cycle pulse every DIV cycles
    assign w_tick = (r_tick_cnt == c_TICK_MAX);

    // Free-running tick counter 0..DIV-1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Digit index advances on each tick and wraps after the last digit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Track the value being converted and latch finished results. A result
    // whose source value has already moved on is dropped so the display only
    // ever shows the latest stable input; the idle compare restarts the
    // conversion for the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_val <= '0;
            r_disp     <= '0;
        end else begin
            if (w_start) begin
                r_last_val <= sum;
            end
            if (w_conv_done && (sum == r_last_val)) begin
                r_disp <= w_conv_bcd;
            end
        end
    end

`ifdef FND_LZ_BLANK_EN
    // A digit is blank when it and every digit above it are zero
    assign w_blank[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz_blank
        assign w_blank[gi] = ~|r_disp[BCD_W-1:4*gi];
    end
`else
    assign w_blank = '0;
`endif

    assign w_digit = r_disp[4*r_idx +: 4];
    assign w_seg   = w_blank[r_idx] ? c_SEG_BLANK : seg_decode(w_digit);

    // Digit enable and segments registered together so they always agree
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fnd_com  <= c_COM_RST;
            r_fnd_data <= c_SEG_0;
        end else begin
            r_fnd_com  <= ~(c_COM_LSB << r_idx);
            r_fnd_data <= w_seg;
        end
    end

    assign fnd_com  = r_fnd_com;
    assign fnd_data = r_fnd_data;
    assign busy     = w_conv_busy;

endmodule
`default_nettype wire
